sc_multi_upcounter: RTL and testbench

SC_MULTI_UPCOUNTER -- requirements
Module: sc_multi_upcounter

---
 rtl/sc_multi_upcounter_if.sv | 36 +++
 rtl/sc_multi_upcounter.sv | 96 +++++++++
 tb/tb_sc_multi_upcounter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_multi_upcounter_if.sv
// Control and status bundle for sc_multi_upcounter: per-channel strobes in,
// combined and per-channel counts plus flags out.
interface sc_multi_upcounter_if #(
  parameter int W = 8,
  parameter int N = 2
);
  logic [N-1:0]   SC_upCOUNTER_upcount_InLow;
  logic [N-1:0]   SC_upCOUNTER_clear_InHigh;
  logic [N-1:0]   SC_upCOUNTER_load_InHigh;
  logic [W-1:0]   SC_upCOUNTER_loadData_InBUS;
  logic           SC_upCOUNTER_saturate_InHigh;
  logic [1:0]     SC_upCOUNTER_combine_InBUS;
  logic [2:0]     SC_upCOUNTER_sel_InBUS;
  logic [W-1:0]   SC_upCOUNTER_data_OutBUS;
  logic [N*W-1:0] SC_upCOUNTER_channel_OutBUS;
  logic [N-1:0]   SC_upCOUNTER_tc_OutHigh;
  logic [N-1:0]   SC_upCOUNTER_overflow_OutHigh;

  modport master (
    output SC_upCOUNTER_upcount_InLow, SC_upCOUNTER_clear_InHigh,
           SC_upCOUNTER_load_InHigh, SC_upCOUNTER_loadData_InBUS,
           SC_upCOUNTER_saturate_InHigh, SC_upCOUNTER_combine_InBUS,
           SC_upCOUNTER_sel_InBUS,
    input  SC_upCOUNTER_data_OutBUS, SC_upCOUNTER_channel_OutBUS,
           SC_upCOUNTER_tc_OutHigh, SC_upCOUNTER_overflow_OutHigh
  );

  modport slave (
    input  SC_upCOUNTER_upcount_InLow, SC_upCOUNTER_clear_InHigh,
           SC_upCOUNTER_load_InHigh, SC_upCOUNTER_loadData_InBUS,
           SC_upCOUNTER_saturate_InHigh, SC_upCOUNTER_combine_InBUS,
           SC_upCOUNTER_sel_InBUS,
    output SC_upCOUNTER_data_OutBUS, SC_upCOUNTER_channel_OutBUS,
           SC_upCOUNTER_tc_OutHigh, SC_upCOUNTER_overflow_OutHigh
  );
endinterface

// File: rtl/sc_multi_upcounter.sv
// N independent up-counters with clear/load/count priority, wrap or saturate
// at LIMIT, registered terminal-count pulse, sticky overflow and a combined view.
module sc_multi_upcounter #(
  parameter int upCOUNTER_DATAWIDTH = 8,
  parameter int upCOUNTER_CHANNELS  = 2,
  parameter int upCOUNTER_LIMIT     = (1 << upCOUNTER_DATAWIDTH) - 1
) (
  input  logic                 SC_upCOUNTER_CLOCK_50,
  input  logic                 SC_upCOUNTER_RESET_InHigh,
  sc_multi_upcounter_if.slave  bus
);

  localparam int            W      = upCOUNTER_DATAWIDTH;
  localparam int            N      = upCOUNTER_CHANNELS;
  localparam logic [W-1:0]  LIM    = W'(upCOUNTER_LIMIT);
  localparam logic [W-1:0]  LIM_M1 = LIM - W'(1);

  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
    return (v > LIM) ? LIM : v;
  endfunction

  logic [W-1:0] cnt_q [N];
  logic [W-1:0] cnt_d [N];
  logic [N-1:0] tc_q, tc_d;
  logic [N-1:0] ovf_q, ovf_d;

  // Next-state: clear beats load beats count; tc only on the LIMIT-1 -> LIMIT step.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      tc_d[i]  = 1'b0;
      ovf_d[i] = ovf_q[i];
      if (bus.SC_upCOUNTER_clear_InHigh[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (bus.SC_upCOUNTER_load_InHigh[i]) begin
        cnt_d[i] = clamp_load(bus.SC_upCOUNTER_loadData_InBUS);
        ovf_d[i] = 1'b0;
      end else if (!bus.SC_upCOUNTER_upcount_InLow[i]) begin
        if (cnt_q[i] == LIM) begin
          if (!bus.SC_upCOUNTER_saturate_InHigh) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
          tc_d[i]  = (cnt_q[i] == LIM_M1);
        end
      end
    end
  end

  always_ff @(posedge SC_upCOUNTER_CLOCK_50 or posedge SC_upCOUNTER_RESET_InHigh) begin
    if (SC_upCOUNTER_RESET_InHigh) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      tc_q  <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  logic [W-1:0]   and_v, or_v, xor_v, sel_v, data_v;
  logic [N*W-1:0] chan_v;

  // Combined view is purely combinational so it tracks the registers in-cycle;
  // an out-of-range select matches no channel and leaves sel_v at zero.
  always_comb begin
    and_v  = '1;
    or_v   = '0;
    xor_v  = '0;
    sel_v  = '0;
    chan_v = '0;
    for (int i = 0; i < N; i++) begin
      and_v = and_v & cnt_q[i];
      or_v  = or_v  | cnt_q[i];
      xor_v = xor_v ^ cnt_q[i];
      if (bus.SC_upCOUNTER_sel_InBUS == 3'(i)) sel_v = cnt_q[i];
      chan_v[i*W +: W] = cnt_q[i];
    end
    case (bus.SC_upCOUNTER_combine_InBUS)
      2'b00:   data_v = and_v;
      2'b01:   data_v = or_v;
      2'b10:   data_v = xor_v;
      default: data_v = sel_v;
    endcase
  end

  assign bus.SC_upCOUNTER_data_OutBUS      = data_v;
  assign bus.SC_upCOUNTER_channel_OutBUS   = chan_v;
  assign bus.SC_upCOUNTER_tc_OutHigh       = tc_q;
  assign bus.SC_upCOUNTER_overflow_OutHigh = ovf_q;

endmodule

// File: tb/tb_sc_multi_upcounter.sv
// Scoreboard bench for sc_multi_upcounter (W=8, N=2, LIMIT=9): directed
// scenarios followed by randomized traffic against a rule-level model.
module tb_sc_multi_upcounter;

  localparam int W   = 8;
  localparam int N   = 2;
  localparam int LIM = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sc_multi_upcounter_if #(.W(W), .N(N)) bus ();

  sc_multi_upcounter #(
    .upCOUNTER_DATAWIDTH(W),
    .upCOUNTER_CHANNELS (N),
    .upCOUNTER_LIMIT    (LIM)
  ) dut (
    .SC_upCOUNTER_CLOCK_50    (clk),
    .SC_upCOUNTER_RESET_InHigh(rst),
    .bus                      (bus.slave)
  );

  typedef struct {
    logic [15:0] ch;
    logic [1:0]  tc;
    logic [1:0]  ov;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_cnt [2];
  bit   m_tc  [2];
  bit   m_ov  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_data(input logic [1:0] cmb, input logic [2:0] sel);
    case (cmb)
      2'b00:   return m_cnt[0] & m_cnt[1];
      2'b01:   return m_cnt[0] | m_cnt[1];
      2'b10:   return m_cnt[0] ^ m_cnt[1];
      default: return (sel < N) ? m_cnt[sel] : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      m_tc[c]  = 0;
      m_ov[c]  = 0;
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, push, wait for the edge.
  task automatic step(input logic [1:0] en_n, input logic [1:0] clr,
                      input logic [1:0] ld, input logic [7:0] ldd,
                      input logic sat, input logic [1:0] cmb, input logic [2:0] sel);
    exp_t e;
    @(negedge clk);
    bus.SC_upCOUNTER_upcount_InLow   = en_n;
    bus.SC_upCOUNTER_clear_InHigh    = clr;
    bus.SC_upCOUNTER_load_InHigh     = ld;
    bus.SC_upCOUNTER_loadData_InBUS  = ldd;
    bus.SC_upCOUNTER_saturate_InHigh = sat;
    bus.SC_upCOUNTER_combine_InBUS   = cmb;
    bus.SC_upCOUNTER_sel_InBUS       = sel;
    for (int c = 0; c < N; c++) begin
      m_tc[c] = 0;
      if (clr[c]) begin
        m_cnt[c] = 0;
        m_ov[c]  = 0;
      end else if (ld[c]) begin
        m_cnt[c] = (int'(ldd) > LIM) ? LIM : int'(ldd);
        m_ov[c]  = 0;
      end else if (!en_n[c]) begin
        if (m_cnt[c] < LIM) begin
          m_cnt[c] = m_cnt[c] + 1;
          m_tc[c]  = (m_cnt[c] == LIM);
        end else if (!sat) begin
          m_cnt[c] = 0;
          m_ov[c]  = 1;
        end
      end
    end
    e.ch   = {8'(m_cnt[1]), 8'(m_cnt[0])};
    e.tc   = {m_tc[1], m_tc[0]};
    e.ov   = {m_ov[1], m_ov[0]};
    e.data = 8'(model_data(cmb, sel));
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic hold_cmb(input logic [1:0] cmb, input logic [2:0] sel, input int exp, input string nm);
    @(negedge clk);
    bus.SC_upCOUNTER_upcount_InLow = 2'b11;
    bus.SC_upCOUNTER_clear_InHigh  = 2'b00;
    bus.SC_upCOUNTER_load_InHigh   = 2'b00;
    bus.SC_upCOUNTER_combine_InBUS = cmb;
    bus.SC_upCOUNTER_sel_InBUS     = sel;
    #1 chk(nm, bus.SC_upCOUNTER_data_OutBUS, exp);
  endtask

  // Monitor: every edge the DUT presents a new state; compare with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_channel",  bus.SC_upCOUNTER_channel_OutBUS,   e.ch);
        chk("sb_tc",       bus.SC_upCOUNTER_tc_OutHigh,       e.tc);
        chk("sb_overflow", bus.SC_upCOUNTER_overflow_OutHigh, e.ov);
        chk("sb_data",     bus.SC_upCOUNTER_data_OutBUS,      e.data);
      end
    end
  end

  initial begin
    bus.SC_upCOUNTER_upcount_InLow   = 2'b11;
    bus.SC_upCOUNTER_clear_InHigh    = 2'b00;
    bus.SC_upCOUNTER_load_InHigh     = 2'b00;
    bus.SC_upCOUNTER_loadData_InBUS  = 8'd0;
    bus.SC_upCOUNTER_saturate_InHigh = 1'b0;
    bus.SC_upCOUNTER_combine_InBUS   = 2'b11;
    bus.SC_upCOUNTER_sel_InBUS       = 3'd0;
    model_reset();

    #5;
    chk("rst_channel", bus.SC_upCOUNTER_channel_OutBUS, 0);
    chk("rst_tc",      bus.SC_upCOUNTER_tc_OutHigh, 0);
    chk("rst_ovf",     bus.SC_upCOUNTER_overflow_OutHigh, 0);
    chk("rst_data",    bus.SC_upCOUNTER_data_OutBUS, 0);
    #10 rst = 1'b0;

    // Count ch0 up to LIMIT, tc pulse for exactly one cycle.
    for (int k = 0; k < 9; k++) step(2'b10, 2'b00, 2'b00, 8'd0, 1'b0, 2'b11, 3'd0);
    #2;
    chk("cnt0_at_limit", bus.SC_upCOUNTER_channel_OutBUS[7:0], 9);
    chk("tc0_pulse",     bus.SC_upCOUNTER_tc_OutHigh[0], 1);
    chk("data_sel0",     bus.SC_upCOUNTER_data_OutBUS, 9);
    step(2'b11, 2'b00, 2'b00, 8'd0, 1'b0, 2'b11, 3'd0);
    #2 chk("tc0_one_cycle", bus.SC_upCOUNTER_tc_OutHigh[0], 0);

    // Wrap and sticky overflow, then clear.
    step(2'b10, 2'b00, 2'b00, 8'd0, 1'b0, 2'b11, 3'd0);
    #2;
    chk("wrap_cnt0", bus.SC_upCOUNTER_channel_OutBUS[7:0], 0);
    chk("wrap_ovf0", bus.SC_upCOUNTER_overflow_OutHigh[0], 1);
    for (int k = 0; k < 5; k++) step(2'b10, 2'b00, 2'b00, 8'd0, 1'b0, 2'b11, 3'd0);
    #2 chk("ovf0_sticky", bus.SC_upCOUNTER_overflow_OutHigh[0], 1);
    step(2'b11, 2'b01, 2'b00, 8'd0, 1'b0, 2'b11, 3'd0);
    #2 chk("clear_ovf0", bus.SC_upCOUNTER_overflow_OutHigh[0], 0);

    // Saturate ch1 at LIMIT.
    step(2'b11, 2'b00, 2'b10, 8'd9, 1'b1, 2'b11, 3'd1);
    for (int k = 0; k < 4; k++) step(2'b01, 2'b00, 2'b00, 8'd0, 1'b1, 2'b11, 3'd1);
    #2;
    chk("sat_cnt1", bus.SC_upCOUNTER_channel_OutBUS[15:8], 9);
    chk("sat_tc1",  bus.SC_upCOUNTER_tc_OutHigh[1], 0);
    chk("sat_ovf1", bus.SC_upCOUNTER_overflow_OutHigh[1], 0);

    // Clear beats load; load clamps to LIMIT without tc.
    step(2'b11, 2'b01, 2'b01, 8'd5, 1'b0, 2'b11, 3'd0);
    #2 chk("clr_over_load", bus.SC_upCOUNTER_channel_OutBUS[7:0], 0);
    step(2'b11, 2'b00, 2'b10, 8'd200, 1'b0, 2'b11, 3'd1);
    #2;
    chk("load_clamp", bus.SC_upCOUNTER_channel_OutBUS[15:8], 9);
    chk("load_no_tc", bus.SC_upCOUNTER_tc_OutHigh[1], 0);

    // Combine modes on cnt0=6, cnt1=3.
    step(2'b11, 2'b00, 2'b01, 8'd6, 1'b0, 2'b00, 3'd0);
    step(2'b11, 2'b00, 2'b10, 8'd3, 1'b0, 2'b00, 3'd0);
    hold_cmb(2'b00, 3'd0, 2, "cmb_and");
    hold_cmb(2'b01, 3'd0, 7, "cmb_or");
    hold_cmb(2'b10, 3'd0, 5, "cmb_xor");
    hold_cmb(2'b11, 3'd1, 3, "cmb_sel1");
    hold_cmb(2'b11, 3'd5, 0, "cmb_sel_oob");

    // Asynchronous reset between edges while both channels count.
    step(2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 2'b01, 3'd0);
    step(2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 2'b01, 3'd0);
    #5 rst = 1'b1;
    #1;
    chk("arst_channel", bus.SC_upCOUNTER_channel_OutBUS, 0);
    chk("arst_data",    bus.SC_upCOUNTER_data_OutBUS, 0);
    chk("arst_tc_ovf",  {bus.SC_upCOUNTER_tc_OutHigh, bus.SC_upCOUNTER_overflow_OutHigh}, 0);
    model_reset();
    #2 rst = 1'b0;
    step(2'b00, 2'b00, 2'b00, 8'd0, 1'b0, 2'b01, 3'd0);
    #2 chk("resume_from_1", bus.SC_upCOUNTER_channel_OutBUS, 16'h0101);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic [1:0] clr, ld;
      logic [7:0] ldd;
      clr[0] = ($urandom_range(0, 15) == 0);
      clr[1] = ($urandom_range(0, 15) == 0);
      ld[0]  = ($urandom_range(0, 11) == 0);
      ld[1]  = ($urandom_range(0, 11) == 0);
      ldd    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      step(2'($urandom_range(0, 3)), clr, ld, ldd, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2 chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
